qclk_bank: RTL
==============

# qclk_bank

Multi-channel qubit-time clock bank for the distributed processor. It holds N_CHAN free-running time counters, one per processor core. Each counter can be loaded with latency compensation, and all counters can be resynchronised at once. Each channel has a one-entry timed-compare unit that pulses when the channel's clock reaches a programmed target. It replaces a per-core single counter and sits between the core ALU/load path and the pulse/trigger scheduling logic.

## Interface
Parameters:
- WIDTH, 32: counter and target width in bits.
- N_CHAN, 4: number of independent clock channels.
- LOAD_LATENCY, 2: constant added to a loaded value to cover ALU pipeline delay; must be less than 2^WIDTH.

Ports (channel c occupies bits [c*WIDTH +: WIDTH] of the packed buses):
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- sync  in  1  global resync; all counters go to 0.
- load_enable  in  N_CHAN  per-channel load strobe.
- in_val  in  N_CHAN*WIDTH  per-channel load values.
- out  out  N_CHAN*WIDTH  per-channel current time (registered).
- cmp_val  in  N_CHAN*WIDTH  per-channel compare target.
- cmp_valid  in  N_CHAN  target valid.
- cmp_ready  out  N_CHAN  channel can accept a target.
- cmp_fire  out  N_CHAN  one-cycle pulse when the target is reached.
- cmp_late  out  N_CHAN  qualifies cmp_fire: the target was already in the past.

## Operation
Counter, per channel, applied in priority order:
- rst: value to 0.
- sync: value to 0. Sync overrides a simultaneous load_enable.
- load_enable: value to in_val + LOAD_LATENCY, modulo 2^WIDTH.
- Otherwise: value + 1, wrapping from 2^WIDTH-1 to 0.

Compare unit, per channel, has two states:
- IDLE: cmp_ready=1. When cmp_valid and cmp_ready are both high, the unit latches cmp_val into target and moves to ARMED.
- ARMED: cmp_ready=0. Each cycle it computes d = value − target as a WIDTH-bit two's-complement signed number.
  - If d ≥ 0: next cycle cmp_fire=1, cmp_late=(d>0), and the state returns to IDLE.
  - If d < 0: the unit stays ARMED.

Compare rules:
- Wrap-safe: the target is reached when it lies within 2^(WIDTH-1) behind the current time.
- A load that jumps past the target produces a late fire. It is never lost.
- sync and load do not disarm a channel. The target is re-evaluated against the new time.
- rst clears the state to IDLE and clears target, cmp_fire and cmp_late.
- A new target cannot be accepted in the fire cycle. cmp_ready rises in the cycle after the fire, together with the IDLE state.

Channels are fully independent except for the shared rst and sync.

## Timing
Reset values:
- out = 0, cmp_ready = all 1, cmp_fire = 0, cmp_late = 0.

Counter:
- Load strobe in cycle k: out = in_val+LOAD_LATENCY in cycle k+1, then +1 per cycle.
- sync in cycle k: out = 0 in cycle k+1.

Compare:
- Target accepted in cycle k: state is ARMED in cycle k+1. The first comparison uses the out visible in cycle k+1.
- out == target in cycle j (armed): cmp_fire=1, cmp_late=0 in cycle j+1. cmp_ready=1 in cycle j+2.
- Fire latency is exactly 1 cycle after the compare condition holds.
- cmp_late is valid only while cmp_fire=1 and is 0 otherwise.

Ports:
- cmp_ready is a registered state decode. It does not depend on cmp_valid.

## Configuration
- QCLK_BANK_CMP_EN defined: the compare units are built as described above.
- QCLK_BANK_CMP_EN undefined: no compare logic is built. cmp_ready, cmp_fire and cmp_late are tied to 0, cmp_val and cmp_valid are ignored, and the counters behave identically.

## Structure
- Shared package qclk_pkg holds:
  - default constants QCLK_WIDTH=32, QCLK_LOAD_LATENCY=2;
  - the compare-state enum (CMP_IDLE, CMP_ARMED).
- Sub-module qclk_chan implements one channel: counter and compare FSM.
- qclk_bank generate-instantiates N_CHAN copies of qclk_chan, fans out rst and sync, and slices the packed buses.

## Test plan
- Reset and free-run: hold rst for 3 cycles, then release. out[0] reads 0,1,2,… and cmp_ready is all 1. Then load in_val=2^32−2 on channel 0. out[0] reads 0 (−2+2 wraps), then 1.
- Load plus sync collision: at one edge, load_enable[1]=1 with in_val=100, and sync=1. out[1]=0 next cycle, with no load applied. Without sync, out[1]=102.
- On-time compare: channel 2 at time 10, target 20 accepted. out[2]=20 in cycle j, then cmp_fire[2]=1 with cmp_late=0 in j+1. Channel 2 is ready in j+2, and all other channels are quiet.
- Late compare via load: target 500 armed, then load in_val=1000. cmp_fire=1 with cmp_late=1 one cycle after out shows 1002.
- Wrap compare: time 0xFFFFFFF0, target 0x00000005. No early fire. The fire arrives after out shows 5, i.e. 21 cycles after the first compare, with cmp_late=0.
- Reset mid-arm and macro-off build: assert rst while ARMED. No fire ever occurs and cmp_ready=1 after reset. With QCLK_BANK_CMP_EN undefined, cmp_ready, cmp_fire and cmp_late are 0 for all stimuli.

Source files
------------

// File: rtl/qclk_pkg.sv
// rtl/qclk_pkg.sv - shared constants and compare-state type for the qubit-time clock bank
package qclk_pkg;

   localparam int QCLK_WIDTH        = 32;
   localparam int QCLK_LOAD_LATENCY = 2;
   localparam int QCLK_N_CHAN       = 4;

   typedef enum logic {
      CMP_IDLE  = 1'b0,
      CMP_ARMED = 1'b1
   } cmp_state_e;

endpackage

// File: rtl/qclk_chan.sv
// rtl/qclk_chan.sv - one clock channel: free-running counter plus one-entry timed compare
// Compare unit is built only when QCLK_BANK_CMP_EN is defined.
module qclk_chan
   import qclk_pkg::*;
#(
   parameter int WIDTH        = QCLK_WIDTH,
   parameter int LOAD_LATENCY = QCLK_LOAD_LATENCY
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sync,
   input  logic             load_enable,
   input  logic [WIDTH-1:0] in_val,
   output logic [WIDTH-1:0] out,
   input  logic [WIDTH-1:0] cmp_val,
   input  logic             cmp_valid,
   output logic             cmp_ready,
   output logic             cmp_fire,
   output logic             cmp_late
);

   localparam logic [WIDTH-1:0] LAT = WIDTH'(LOAD_LATENCY);

   logic [WIDTH-1:0] value;

   always_ff @(posedge clk) begin
      if (rst) begin
         value <= '0;
      end else if (sync) begin
         value <= '0;
      end else if (load_enable) begin
         value <= in_val + LAT;
      end else begin
         value <= value + 1'b1;
      end
   end

   assign out = value;

`ifdef QCLK_BANK_CMP_EN
   cmp_state_e       state;
   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] diff;
   logic             ready_q;
   logic             fire_q;
   logic             late_q;

   // Sign bit of (value - target) gives the wrap-safe "reached" test.
   assign diff = value - target;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CMP_IDLE;
         target  <= '0;
         ready_q <= 1'b1;
         fire_q  <= 1'b0;
         late_q  <= 1'b0;
      end else begin
         fire_q <= 1'b0;
         late_q <= 1'b0;
         case (state)
            CMP_IDLE: begin
               if (cmp_valid && ready_q) begin
                  target  <= cmp_val;
                  state   <= CMP_ARMED;
                  ready_q <= 1'b0;
               end
            end
            CMP_ARMED: begin
               // The fire cycle is spent still armed so no target is taken alongside the pulse.
               if (fire_q) begin
                  state   <= CMP_IDLE;
                  ready_q <= 1'b1;
               end else if (!diff[WIDTH-1]) begin
                  fire_q <= 1'b1;
                  late_q <= |diff;
               end
            end
            default: begin
               state   <= CMP_IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign cmp_ready = ready_q;
   assign cmp_fire  = fire_q;
   assign cmp_late  = late_q;
`else
   logic unused_cmp;

   assign unused_cmp = ^{cmp_val, cmp_valid};
   assign cmp_ready  = 1'b0;
   assign cmp_fire   = 1'b0;
   assign cmp_late   = 1'b0;
`endif

endmodule

// File: rtl/qclk_bank.sv
// rtl/qclk_bank.sv - bank of N_CHAN qubit-time clock channels with shared rst and sync
// Compare units are built only when QCLK_BANK_CMP_EN is defined.
module qclk_bank
   import qclk_pkg::*;
#(
   parameter int WIDTH        = QCLK_WIDTH,
   parameter int N_CHAN       = QCLK_N_CHAN,
   parameter int LOAD_LATENCY = QCLK_LOAD_LATENCY
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    sync,
   input  logic [N_CHAN-1:0]       load_enable,
   input  logic [N_CHAN*WIDTH-1:0] in_val,
   output logic [N_CHAN*WIDTH-1:0] out,
   input  logic [N_CHAN*WIDTH-1:0] cmp_val,
   input  logic [N_CHAN-1:0]       cmp_valid,
   output logic [N_CHAN-1:0]       cmp_ready,
   output logic [N_CHAN-1:0]       cmp_fire,
   output logic [N_CHAN-1:0]       cmp_late
);

   for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
      qclk_chan #(
         .WIDTH        (WIDTH),
         .LOAD_LATENCY (LOAD_LATENCY)
      ) u_chan (
         .clk         (clk),
         .rst         (rst),
         .sync        (sync),
         .load_enable (load_enable[c]),
         .in_val      (in_val[c*WIDTH +: WIDTH]),
         .out         (out[c*WIDTH +: WIDTH]),
         .cmp_val     (cmp_val[c*WIDTH +: WIDTH]),
         .cmp_valid   (cmp_valid[c]),
         .cmp_ready   (cmp_ready[c]),
         .cmp_fire    (cmp_fire[c]),
         .cmp_late    (cmp_late[c])
      );
   end

endmodule
